// File: rtl/iq_deinterleave_buffer_pkg.sv
// Shared constants, width helpers and frame type for the IQ deinterleave buffer.
// Optional statistics ports are enabled by defining IQ_DEINTLV_STATS_EN.
package iq_buf_pkg;

    localparam int unsigned DATA_W_DEF = 12;
    localparam int unsigned LANES_DEF  = 2;
    localparam int unsigned DEPTH_DEF  = 16;
    localparam int unsigned FRAME_W    = LANES_DEF * DATA_W_DEF;
    localparam int unsigned STAT_W     = 16;

    // Frame-slot index width; pointers carry one extra wrap bit on top.
    function automatic int unsigned addr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic int unsigned lane_w(input int unsigned lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    typedef logic [FRAME_W-1:0] frame_t;

endpackage

// File: rtl/iq_deinterleave_buffer_if.sv
// Sample-in / frame-out valid-ready bus of the IQ deinterleave buffer.
// master = stream source and frame sink, slave = the buffer.
interface iq_deinterleave_buffer_if
    import iq_buf_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned LANES  = LANES_DEF
);
    logic [DATA_W-1:0]       in_data;
    logic                    in_valid;
    logic                    in_first;
    logic                    in_ready;
    logic [LANES*DATA_W-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output in_data, in_valid, in_first, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, in_first, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/iq_deinterleave_buffer_frame_ram.sv
// Frame storage: DEPTH slots of LANES samples, per-lane write enable, async read.
// Lane 0 lives in the MSBs of a slot. The array is intentionally not reset.
module iq_frame_ram
    import iq_buf_pkg::*;
#(
    parameter  int unsigned DATA_W = DATA_W_DEF,
    parameter  int unsigned LANES  = LANES_DEF,
    parameter  int unsigned DEPTH  = DEPTH_DEF,
    localparam int unsigned ADDR_W = addr_w(DEPTH)
) (
    input  logic                    clk,
    input  logic [LANES-1:0]        i_we,
    input  logic [ADDR_W-1:0]       i_wr_addr,
    input  logic [DATA_W-1:0]       i_wr_data,
    input  logic [ADDR_W-1:0]       i_rd_addr,
    output logic [LANES*DATA_W-1:0] o_rd_data
);

    logic [LANES*DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int unsigned l = 0; l < LANES; l++) begin
            if (i_we[l]) begin
                r_mem[i_wr_addr][(LANES-1-l)*DATA_W +: DATA_W] <= i_wr_data;
            end
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/iq_deinterleave_buffer.sv
// Deinterleaves a round-robin sample stream into LANES-wide frames held in a FIFO;
// only complete frames are visible. Define IQ_DEINTLV_STATS_EN for resync/stall stats.
module iq_deinterleave_buffer
    import iq_buf_pkg::*;
#(
    parameter  int unsigned DATA_W = DATA_W_DEF,
    parameter  int unsigned LANES  = LANES_DEF,
    parameter  int unsigned DEPTH  = DEPTH_DEF,
    localparam int unsigned ADDR_W = addr_w(DEPTH),
    localparam int unsigned PTR_W  = ADDR_W + 1,
    localparam int unsigned LVL_W  = ADDR_W + 1,
    localparam int unsigned LANE_W = lane_w(LANES),
    localparam int unsigned FRM_W  = LANES * DATA_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sclr,
    iq_deinterleave_buffer_if.slave bus,
    output logic [LVL_W-1:0]        level
`ifdef IQ_DEINTLV_STATS_EN
    ,
    output logic [STAT_W-1:0]       resync_cnt,
    output logic                    stall_seen
`endif
);

    logic [PTR_W-1:0]  r_wr_addr;
    logic [PTR_W-1:0]  r_rd_addr;
    logic [LANE_W-1:0] r_wr_lane;
    logic [LVL_W-1:0]  r_level;
    logic              r_out_valid;
    logic              r_in_ready;
    logic [FRM_W-1:0]  r_out_data;

    logic              w_push;
    logic              w_pop;
    logic              w_commit;
    logic [LANE_W-1:0] w_lane;
    logic [LANES-1:0]  w_we;
    logic [PTR_W-1:0]  w_wr_addr_nxt;
    logic [PTR_W-1:0]  w_rd_addr_nxt;
    logic [LANE_W-1:0] w_wr_lane_nxt;
    logic [LVL_W-1:0]  w_level_nxt;
    logic              w_out_valid_nxt;
    logic              w_in_ready_nxt;
    logic [FRM_W-1:0]  w_ram_rd;
    logic [FRM_W-1:0]  w_out_data_nxt;

    iq_frame_ram #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk       (clk),
        .i_we      (w_we),
        .i_wr_addr (r_wr_addr[ADDR_W-1:0]),
        .i_wr_data (bus.in_data),
        .i_rd_addr (w_rd_addr_nxt[ADDR_W-1:0]),
        .o_rd_data (w_ram_rd)
    );

    // Next-state: lane steering, commit/pop pointer updates and the next head frame.
    always_comb begin
        w_push          = bus.in_valid && r_in_ready && !sclr;
        w_pop           = r_out_valid && bus.out_ready && !sclr;
        w_lane          = bus.in_first ? '0 : r_wr_lane;
        w_commit        = w_push && (w_lane == LANE_W'(LANES - 1));
        w_we            = '0;
        w_wr_addr_nxt   = r_wr_addr;
        w_wr_lane_nxt   = r_wr_lane;
        w_rd_addr_nxt   = r_rd_addr;

        if (w_push) begin
            w_we[w_lane] = 1'b1;
            if (w_commit) begin
                w_wr_addr_nxt = r_wr_addr + PTR_W'(1);
                w_wr_lane_nxt = '0;
            end else begin
                w_wr_lane_nxt = w_lane + LANE_W'(1);
            end
        end

        if (w_pop) begin
            w_rd_addr_nxt = r_rd_addr + PTR_W'(1);
        end

        if (sclr) begin
            w_wr_addr_nxt = '0;
            w_rd_addr_nxt = '0;
            w_wr_lane_nxt = '0;
        end

        // Wrap-bit pointer difference is exactly the stored frame count 0..DEPTH.
        w_level_nxt     = LVL_W'(w_wr_addr_nxt - w_rd_addr_nxt);
        w_out_valid_nxt = (w_level_nxt != '0);
        w_in_ready_nxt  = (w_level_nxt != LVL_W'(DEPTH));

        // A frame committing into the new head slot is not in the array yet: bypass its last lane.
        w_out_data_nxt = w_ram_rd;
        if (w_commit && (r_wr_addr == w_rd_addr_nxt)) begin
            w_out_data_nxt[DATA_W-1:0] = bus.in_data;
        end
        if (!w_out_valid_nxt) begin
            w_out_data_nxt = '0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_addr   <= '0;
            r_rd_addr   <= '0;
            r_wr_lane   <= '0;
            r_level     <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_data  <= '0;
        end else begin
            r_wr_addr   <= w_wr_addr_nxt;
            r_rd_addr   <= w_rd_addr_nxt;
            r_wr_lane   <= w_wr_lane_nxt;
            r_level     <= w_level_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_data  <= w_out_data_nxt;
        end
    end

    assign level         = r_level;
    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;

`ifdef IQ_DEINTLV_STATS_EN
    logic [STAT_W-1:0] r_resync_cnt;
    logic              r_stall_seen;

    // Saturating discard counter and sticky back-pressure flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resync_cnt <= '0;
            r_stall_seen <= 1'b0;
        end else if (sclr) begin
            r_resync_cnt <= '0;
            r_stall_seen <= 1'b0;
        end else begin
            if (w_push && bus.in_first && (r_wr_lane != '0) && (r_resync_cnt != '1)) begin
                r_resync_cnt <= r_resync_cnt + STAT_W'(1);
            end
            if (bus.in_valid && !r_in_ready) begin
                r_stall_seen <= 1'b1;
            end
        end
    end

    assign resync_cnt = r_resync_cnt;
    assign stall_seen = r_stall_seen;
`endif

endmodule

// File: tb/tb_iq_deinterleave_buffer.sv
// Bench for iq_deinterleave_buffer: vector table, directed corner sequences and a
// randomized run against a frame-queue model. Stats checks follow IQ_DEINTLV_STATS_EN.
module tb_iq_deinterleave_buffer;
    import iq_buf_pkg::*;

    localparam int unsigned DW = 12;
    localparam int unsigned LN = 2;
    localparam int unsigned DP = 16;
    localparam int unsigned LW = 5;

    logic          clk;
    logic          rst_n;
    logic          sclr;
    logic [LW-1:0] level;
`ifdef IQ_DEINTLV_STATS_EN
    logic [15:0]   resync_cnt;
    logic          stall_seen;
`endif

    iq_deinterleave_buffer_if #(.DATA_W(DW), .LANES(LN)) bus ();

    iq_deinterleave_buffer #(.DATA_W(DW), .LANES(LN), .DEPTH(DP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sclr  (sclr),
        .bus   (bus),
        .level (level)
`ifdef IQ_DEINTLV_STATS_EN
        ,
        .resync_cnt (resync_cnt),
        .stall_seen (stall_seen)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;

    // Model: queue of complete frames plus the samples of the frame being assembled.
    frame_t        mq[$];
    logic [DW-1:0] part[LN];
    int            pcnt;
    int            m_resync;
    bit            m_stall;

    typedef struct {
        logic          sc;
        logic          v;
        logic          f;
        logic [DW-1:0] d;
        logic          r;
        logic          ev;
        frame_t        ed;
        int            el;
        logic          eir;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        pcnt     = 0;
        m_resync = 0;
        m_stall  = 0;
    endtask

    function automatic frame_t pack_part();
        frame_t f = '0;
        for (int l = 0; l < LN; l++) f = (f << DW) | frame_t'(part[l]);
        return f;
    endfunction

    task automatic model_step(input logic sc, input logic v, input logic f,
                              input logic [DW-1:0] d, input logic r);
        int sz = mq.size();
        if (sc) begin
            model_reset();
            return;
        end
        if (v && sz == DP) m_stall = 1;
        if (v && sz != DP) begin
            if (f) begin
                if (pcnt != 0 && m_resync < 65535) m_resync++;
                pcnt = 0;
            end
            part[pcnt] = d;
            pcnt++;
            if (pcnt == LN) begin
                mq.push_back(pack_part());
                pcnt = 0;
            end
        end
        if (r && sz != 0) void'(mq.pop_front());
    endtask

    task automatic check_outputs();
        frame_t e = (mq.size() != 0) ? mq[0] : '0;
        check("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
        check("level",     64'(level),         64'(mq.size()));
        check("in_ready",  64'(bus.in_ready),  64'(mq.size() != DP));
        check("out_data",  64'(bus.out_data),  64'(e));
`ifdef IQ_DEINTLV_STATS_EN
        check("resync_cnt", 64'(resync_cnt), 64'(m_resync));
        check("stall_seen", 64'(stall_seen), 64'(m_stall));
`endif
    endtask

    // Drive one cycle's inputs, step the model, clock, then compare just after the edge.
    task automatic cycle(input logic sc, input logic v, input logic f,
                         input logic [DW-1:0] d, input logic r);
        sclr          = sc;
        bus.in_valid  = v;
        bus.in_first  = f;
        bus.in_data   = d;
        bus.out_ready = r;
        model_step(sc, v, f, d, r);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic add_vec(input logic sc, input logic v, input logic f, input logic [DW-1:0] d,
                           input logic r, input logic ev, input frame_t ed, input int el,
                           input logic eir);
        vec_t t;
        t.sc = sc; t.v = v; t.f = f; t.d = d; t.r = r;
        t.ev = ev; t.ed = ed; t.el = el; t.eir = eir;
        tbl.push_back(t);
    endtask

    task automatic run_table(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            cycle(tbl[i].sc, tbl[i].v, tbl[i].f, tbl[i].d, tbl[i].r);
            check($sformatf("tbl%0d_valid", i), 64'(bus.out_valid), 64'(tbl[i].ev));
            check($sformatf("tbl%0d_data", i),  64'(bus.out_data),  64'(tbl[i].ed));
            check($sformatf("tbl%0d_level", i), 64'(level),         64'(tbl[i].el));
            check($sformatf("tbl%0d_inrdy", i), 64'(bus.in_ready),  64'(tbl[i].eir));
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        sclr    = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_first  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        model_reset();

        // Two pushes of frame A/B, then pop both (sample order I,Q).
        add_vec(0, 1, 1, 12'h111, 1, 0, 24'h0,      0, 1);
        add_vec(0, 1, 0, 12'h222, 1, 1, 24'h111222, 1, 1);
        add_vec(0, 1, 1, 12'h333, 1, 0, 24'h0,      0, 1);
        add_vec(0, 1, 0, 12'h444, 1, 1, 24'h333444, 1, 1);
        add_vec(0, 0, 0, 12'h000, 1, 0, 24'h0,      0, 1);
        // Resync: the lone 0xAAA is discarded.
        add_vec(0, 1, 1, 12'hAAA, 0, 0, 24'h0,      0, 1);
        add_vec(0, 1, 1, 12'hBBB, 0, 0, 24'h0,      0, 1);
        add_vec(0, 1, 0, 12'hCCC, 0, 1, 24'hBBBCCC, 1, 1);
        add_vec(0, 0, 0, 12'h000, 1, 0, 24'h0,      0, 1);
        // Flush with a stored frame and a half frame; concurrent push/pop ignored.
        add_vec(0, 1, 1, 12'h777, 0, 0, 24'h0,      0, 1);
        add_vec(0, 1, 0, 12'h888, 0, 1, 24'h777888, 1, 1);
        add_vec(0, 1, 1, 12'h999, 0, 1, 24'h777888, 1, 1);
        add_vec(1, 1, 0, 12'hEEE, 1, 0, 24'h0,      0, 1);
        add_vec(0, 1, 1, 12'h5A5, 0, 0, 24'h0,      0, 1);
        add_vec(0, 1, 0, 12'h0F0, 0, 1, 24'h5A50F0, 1, 1);
        add_vec(0, 0, 0, 12'h000, 1, 0, 24'h0,      0, 1);
        // Free-running alignment without in_first.
        add_vec(0, 1, 0, 12'h123, 0, 0, 24'h0,      0, 1);
        add_vec(0, 1, 0, 12'h456, 0, 1, 24'h123456, 1, 1);
        add_vec(0, 0, 0, 12'h000, 1, 0, 24'h0,      0, 1);

        repeat (2) @(posedge clk);
        #3;
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_level",     64'(level),         64'(0));
        check("rst_in_ready",  64'(bus.in_ready),  64'(1));
        check("rst_out_data",  64'(bus.out_data),  64'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs();

        run_table(0, 9);
`ifdef IQ_DEINTLV_STATS_EN
        check("t3_resync_cnt", 64'(resync_cnt), 64'(1));
`endif
        run_table(9, tbl.size());

        // Fill to DEPTH with no reads, then keep offering samples while full.
        for (int i = 0; i < 2 * DP; i++) cycle(0, 1, (i % 2) == 0, DW'(i * 37 + 5), 0);
        check("t2_level_full", 64'(level),        64'(DP));
        check("t2_in_ready",   64'(bus.in_ready), 64'(0));
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 12'hFFF, 0);
        check("t2_level_held", 64'(level), 64'(DP));
        cycle(0, 0, 0, '0, 1);
        check("t2_ready_after_pop", 64'(bus.in_ready), 64'(1));
        check("t2_level_after_pop", 64'(level),        64'(DP - 1));
        for (int i = 0; i < DP; i++) cycle(0, 0, 0, '0, 1);

        // Level 3, frame-completing push coincides with a pop; 40 frames wrap the pointers.
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 1, DW'(12'h100 + i), 0);
            cycle(0, 1, 0, DW'(12'h200 + i), 0);
        end
        for (int i = 0; i < 40; i++) begin
            cycle(0, 1, 1, DW'(12'h300 + i), 0);
            cycle(0, 1, 0, DW'(12'h600 + i), 1);
            check("t4_level_steady", 64'(level), 64'(3));
        end
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, '0, 1);

        // Randomized traffic: fill-biased phase, then drain-biased phase.
        for (int i = 0; i < 3000; i++) begin
            logic sc, v, f, r;
            sc = ($urandom_range(63) == 0);
            v  = ($urandom_range(3) != 0);
            f  = ($urandom_range(5) == 0);
            r  = (i < 1500) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
            cycle(sc, v, f, DW'($urandom), r);
        end

        // Async reset mid-frame and mid-read, asserted between clock edges.
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, DW'(12'h700 + i), 0);
        for (int i = 0; i < DP * 2; i++) cycle(0, 1, 0, DW'(12'h800 + i), 0);
        bus.in_valid  = 1'b1;
        bus.in_first  = 1'b1;
        bus.in_data   = 12'hABC;
        bus.out_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_out_valid", 64'(bus.out_valid), 64'(0));
        check("arst_level",     64'(level),         64'(0));
        check("arst_in_ready",  64'(bus.in_ready),  64'(1));
        check("arst_out_data",  64'(bus.out_data),  64'(0));
`ifdef IQ_DEINTLV_STATS_EN
        check("arst_stall_seen", 64'(stall_seen), 64'(0));
        check("arst_resync_cnt", 64'(resync_cnt), 64'(0));
`endif
        bus.in_valid  = 1'b0;
        bus.in_first  = 1'b0;
        bus.out_ready = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs();
        cycle(0, 1, 0, 12'h321, 0);
        cycle(0, 1, 0, 12'h654, 0);
        check("post_rst_frame", 64'(bus.out_data), 64'(24'h321654));
        cycle(0, 0, 0, '0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
